// File: rtl/regfile_write_sequencer.sv
// regfile_write_sequencer
// Write-side front end for the 32 x 64-bit register file. Writeback requests
// arrive on a valid/ready handshake and sit in a small in-order FIFO. One write
// per cycle is presented on the register file port (RW/BusW/RegWr). Writes to
// X31 (XZR) are accepted but discarded. Pending-write hazard flags and
// youngest-data forwarding are reported for the two read addresses.
//
// Ports:
//   Clk            clock, all state updates on posedge
//   ResetN         synchronous active-low reset
//   WrReq/WrReady  request handshake; WrRW/WrData carry the request
//   Hold           freeze draining; the queue still accepts requests
//   RW/BusW/RegWr  registered register file write port
//   RA/RB          read addresses checked for pending writes
//   PendA/PendB    a write to RA/RB is queued or being presented
//   FwdA/FwdB      youngest pending data for RA/RB, 0 when none
module regfile_write_sequencer #(
    parameter int DEPTH  = 4,
    parameter int DATA_W = 64
) (
    input  logic              Clk,
    input  logic              ResetN,
    input  logic              WrReq,
    output logic              WrReady,
    input  logic [4:0]        WrRW,
    input  logic [DATA_W-1:0] WrData,
    input  logic              Hold,
    output logic [4:0]        RW,
    output logic [DATA_W-1:0] BusW,
    output logic              RegWr,
    input  logic [4:0]        RA,
    input  logic [4:0]        RB,
    output logic              PendA,
    output logic              PendB,
    output logic [DATA_W-1:0] FwdA,
    output logic [DATA_W-1:0] FwdB
);

    localparam int         AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW:0] FULL = (AW+1)'(DEPTH);
    localparam logic [4:0]  XZR  = 5'd31;

    logic [4:0]        r_q_rw   [DEPTH];
    logic [DATA_W-1:0] r_q_data [DEPTH];
    logic [AW-1:0]     r_wr_ptr;
    logic [AW-1:0]     r_rd_ptr;
    logic [AW:0]       r_count;
    logic [4:0]        r_rw;
    logic [DATA_W-1:0] r_busw;
    logic              r_regwr;

    logic              w_ready;
    logic              w_store;
    logic              w_empty;
    logic              w_pop;
    logic              w_direct;
    logic              w_push;
    logic [AW-1:0]     w_idx;
    logic              w_pend_a;
    logic              w_pend_b;
    logic [DATA_W-1:0] w_fwd_a;
    logic [DATA_W-1:0] w_fwd_b;

    assign w_ready  = ResetN & (r_count < FULL);
    // XZR requests complete the handshake but are never stored or written
    assign w_store  = WrReq & w_ready & (WrRW != XZR);
    assign w_empty  = (r_count == '0);
    assign w_pop    = ~Hold & ~w_empty;
    // Empty queue and not held: the request skips the queue entirely
    assign w_direct = ~Hold & w_empty & w_store;
    assign w_push   = w_store & ~w_direct;

    always_ff @(posedge Clk) begin
        if (!ResetN) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_regwr  <= 1'b0;
            r_rw     <= '0;
            r_busw   <= '0;
        end else begin
            if (w_pop) begin
                r_rw     <= r_q_rw[r_rd_ptr];
                r_busw   <= r_q_data[r_rd_ptr];
                r_regwr  <= 1'b1;
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end else if (w_direct) begin
                r_rw    <= WrRW;
                r_busw  <= WrData;
                r_regwr <= 1'b1;
            end else begin
                r_regwr <= 1'b0;
            end

            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end

            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Queue storage needs no reset; only entries inside the count are ever read
    always_ff @(posedge Clk) begin
        if (w_push) begin
            r_q_rw[r_wr_ptr]   <= WrRW;
            r_q_data[r_wr_ptr] <= WrData;
        end
    end

    // Scan oldest to youngest: output stage first, then queue head to tail,
    // so the last match seen is the youngest pending write.
    always_comb begin
        w_pend_a = 1'b0;
        w_pend_b = 1'b0;
        w_fwd_a  = '0;
        w_fwd_b  = '0;
        w_idx    = '0;
        if (r_regwr && (r_rw == RA)) begin
            w_pend_a = 1'b1;
            w_fwd_a  = r_busw;
        end
        if (r_regwr && (r_rw == RB)) begin
            w_pend_b = 1'b1;
            w_fwd_b  = r_busw;
        end
        for (int k = 0; k < DEPTH; k++) begin
            w_idx = r_rd_ptr + AW'(k);
            if ((AW+1)'(k) < r_count) begin
                if (r_q_rw[w_idx] == RA) begin
                    w_pend_a = 1'b1;
                    w_fwd_a  = r_q_data[w_idx];
                end
                if (r_q_rw[w_idx] == RB) begin
                    w_pend_b = 1'b1;
                    w_fwd_b  = r_q_data[w_idx];
                end
            end
        end
        if (RA == XZR) begin
            w_pend_a = 1'b0;
            w_fwd_a  = '0;
        end
        if (RB == XZR) begin
            w_pend_b = 1'b0;
            w_fwd_b  = '0;
        end
    end

    assign WrReady = w_ready;
    assign RW      = r_rw;
    assign BusW    = r_busw;
    assign RegWr   = r_regwr;
    assign PendA   = w_pend_a;
    assign PendB   = w_pend_b;
    assign FwdA    = w_fwd_a;
    assign FwdB    = w_fwd_b;

endmodule

// File: tb/tb_regfile_write_sequencer.sv
// Self-checking bench for regfile_write_sequencer: directed scenarios followed
// by random traffic, all compared against a queue-based reference model.
module tb_regfile_write_sequencer;

    localparam int DEPTH  = 4;
    localparam int DATA_W = 64;

    logic              Clk;
    logic              ResetN;
    logic              WrReq;
    logic              WrReady;
    logic [4:0]        WrRW;
    logic [DATA_W-1:0] WrData;
    logic              Hold;
    logic [4:0]        RW;
    logic [DATA_W-1:0] BusW;
    logic              RegWr;
    logic [4:0]        RA;
    logic [4:0]        RB;
    logic              PendA;
    logic              PendB;
    logic [DATA_W-1:0] FwdA;
    logic [DATA_W-1:0] FwdB;

    regfile_write_sequencer #(.DEPTH(DEPTH), .DATA_W(DATA_W)) dut (
        .Clk(Clk), .ResetN(ResetN), .WrReq(WrReq), .WrReady(WrReady),
        .WrRW(WrRW), .WrData(WrData), .Hold(Hold), .RW(RW), .BusW(BusW),
        .RegWr(RegWr), .RA(RA), .RB(RB), .PendA(PendA), .PendB(PendB),
        .FwdA(FwdA), .FwdB(FwdB)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    typedef struct {
        logic [4:0]        rw;
        logic [DATA_W-1:0] data;
    } ent_t;

    ent_t              m_q[$];
    logic              m_regwr;
    logic [4:0]        m_rw;
    logic [DATA_W-1:0] m_bus;
    bit                m_known = 0;

    int vectors    = 0;
    int miscompares = 0;

    task automatic chk(input string tag, input logic [DATA_W-1:0] obs,
                       input logic [DATA_W-1:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic void m_pend(input logic [4:0] a, output logic p,
                                   output logic [DATA_W-1:0] f);
        p = 1'b0;
        f = '0;
        if (a != 5'd31) begin
            if (m_regwr && m_rw == a) begin
                p = 1'b1;
                f = m_bus;
            end
            foreach (m_q[i]) begin
                if (m_q[i].rw == a) begin
                    p = 1'b1;
                    f = m_q[i].data;
                end
            end
        end
    endfunction

    // Apply one cycle of stimulus, check combinational outputs before the
    // edge, advance the model at the edge, then check the write port.
    task automatic cyc(input logic rn, input logic req, input logic [4:0] rw,
                       input logic [DATA_W-1:0] d, input logic hold,
                       input logic [4:0] ra, input logic [4:0] rb);
        logic              ready, store, pa, pb;
        logic [DATA_W-1:0] fa, fb;
        ent_t              e;
        ResetN = rn; WrReq = req; WrRW = rw; WrData = d; Hold = hold;
        RA = ra; RB = rb;
        #1;
        ready = rn && (m_q.size() < DEPTH);
        if (m_known) begin
            m_pend(ra, pa, fa);
            m_pend(rb, pb, fb);
            chk("WrReady", 64'(WrReady), 64'(ready));
            chk("PendA", 64'(PendA), 64'(pa));
            chk("FwdA", FwdA, fa);
            chk("PendB", 64'(PendB), 64'(pb));
            chk("FwdB", FwdB, fb);
        end
        @(posedge Clk);
        if (!rn) begin
            m_q.delete();
            m_regwr = 1'b0;
            m_rw    = '0;
            m_bus   = '0;
            m_known = 1;
        end else if (m_known) begin
            store = req && ready && (rw != 5'd31);
            e.rw   = rw;
            e.data = d;
            if (hold) begin
                m_regwr = 1'b0;
                if (store) m_q.push_back(e);
            end else if (m_q.size() > 0) begin
                ent_t h;
                h = m_q.pop_front();
                m_rw = h.rw; m_bus = h.data; m_regwr = 1'b1;
                if (store) m_q.push_back(e);
            end else if (store) begin
                m_rw = rw; m_bus = d; m_regwr = 1'b1;
            end else begin
                m_regwr = 1'b0;
            end
        end
        #1;
        if (m_known) begin
            chk("RegWr", 64'(RegWr), 64'(m_regwr));
            chk("RW", 64'(RW), 64'(m_rw));
            chk("BusW", BusW, m_bus);
        end
    endtask

    initial begin
        logic [4:0] r;
        logic [4:0] a;
        logic [4:0] b;

        // Reset for two cycles
        cyc(0, 0, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0, 0);
        chk("rst_RegWr", 64'(RegWr), 64'd0);
        chk("rst_RW", 64'(RW), 64'd0);
        chk("rst_BusW", BusW, 64'd0);
        chk("rst_WrReady", 64'(WrReady), 64'd0);
        cyc(1, 0, 0, 0, 0, 2, 3);
        chk("idle_WrReady", 64'(WrReady), 64'd1);
        chk("idle_PendA", 64'(PendA), 64'd0);

        // Direct path, zero latency
        cyc(1, 1, 5, 64'h1234, 0, 0, 0);
        chk("direct_RegWr", 64'(RegWr), 64'd1);
        chk("direct_RW", 64'(RW), 64'd5);
        chk("direct_BusW", BusW, 64'h1234);
        cyc(1, 0, 0, 0, 0, 0, 0);
        chk("direct_after", 64'(RegWr), 64'd0);

        // Fill under Hold, then drain in order
        for (int i = 1; i <= 4; i++) begin
            cyc(1, 1, 5'(i), 64'(8'hA0 + i), 1, 0, 0);
            chk("fill_RegWr", 64'(RegWr), 64'd0);
        end
        chk("full_WrReady", 64'(WrReady), 64'd0);
        cyc(1, 1, 6, 64'hBAD, 1, 6, 0);
        chk("full_noacc_PendA", 64'(PendA), 64'd0);
        for (int i = 1; i <= 4; i++) begin
            cyc(1, 0, 0, 0, 0, 0, 0);
            chk("drain_RegWr", 64'(RegWr), 64'd1);
            chk("drain_RW", 64'(RW), 64'(i));
            chk("drain_BusW", BusW, 64'(8'hA0 + i));
        end
        cyc(1, 0, 0, 0, 0, 0, 0);
        chk("drain_done", 64'(RegWr), 64'd0);

        // XZR drop
        cyc(1, 1, 31, 64'hDEAD, 0, 31, 0);
        chk("xzr_RegWr", 64'(RegWr), 64'd0);
        chk("xzr_PendA", 64'(PendA), 64'd0);
        cyc(1, 1, 7, 64'h77, 0, 31, 0);
        chk("x7_RW", 64'(RW), 64'd7);
        chk("x7_BusW", BusW, 64'h77);
        cyc(1, 0, 0, 0, 0, 31, 0);
        chk("x7_once", 64'(RegWr), 64'd0);

        // Hazard / youngest forwarding
        cyc(1, 1, 9, 64'h10, 1, 0, 0);
        cyc(1, 1, 9, 64'h20, 1, 0, 0);
        cyc(1, 0, 0, 0, 1, 9, 3);
        chk("haz_PendA", 64'(PendA), 64'd1);
        chk("haz_FwdA", FwdA, 64'h20);
        chk("haz_PendB", 64'(PendB), 64'd0);
        chk("haz_FwdB", FwdB, 64'd0);
        cyc(1, 0, 0, 0, 0, 9, 3);
        cyc(1, 0, 0, 0, 0, 9, 3);
        chk("haz_last_BusW", BusW, 64'h20);
        cyc(1, 0, 0, 0, 0, 9, 3);

        // Simultaneous push/pop at count 3, then reset mid-stream
        for (int i = 0; i < 3; i++) cyc(1, 1, 5'(10 + i), 64'(16'hC00 + i), 1, 0, 0);
        for (int i = 0; i < 5; i++) begin
            cyc(1, 1, 5'(13 + i), 64'(16'hC03 + i), 0, 0, 0);
            chk("pp_RW", 64'(RW), 64'(10 + i));
            chk("pp_WrReady", 64'(WrReady), 64'd1);
        end
        cyc(0, 1, 20, 64'h1, 0, 15, 16);
        chk("midrst_RegWr", 64'(RegWr), 64'd0);
        cyc(1, 0, 0, 0, 0, 15, 16);
        chk("midrst_PendA", 64'(PendA), 64'd0);
        chk("midrst_RegWr2", 64'(RegWr), 64'd0);

        // Random traffic
        for (int n = 0; n < 600; n++) begin
            r = 5'($urandom_range(0, 5)); if (r == 5) r = 31;
            a = 5'($urandom_range(0, 5)); if (a == 5) a = 31;
            b = 5'($urandom_range(0, 5)); if (b == 5) b = 31;
            cyc(($urandom_range(0, 99) >= 2),
                ($urandom_range(0, 9) < 7),
                r, {$urandom, $urandom},
                ($urandom_range(0, 9) < 4),
                a, b);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
